instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset; bits [1:0] SHALL be 00.
REQ-002 Parameter XLEN, default 32, is the width of the PC and instruction.
REQ-003 clk_i  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 stall_i  in  1  hazard hold from ID: keep the current PC.
REQ-006 branch_i  in  1  redirect request from ID, held level while the pipeline is frozen.
REQ-007 branch_target_i  in  XLEN  redirect address.
REQ-008 imem_req_o  out  1  instruction-memory request.
REQ-009 imem_addr_o  out  XLEN  request address, always equal to pc_o.
REQ-010 imem_ack_i  in  1  data valid; may assert in the same cycle as imem_req_o (zero-wait hit).
REQ-011 imem_data_i  in  XLEN  fetched word, valid only when imem_ack_i=1.
REQ-012 pc_o  out  XLEN  address of the instruction presented on inst_o; feeds the IF/ID pc input.
REQ-013 inst_o  out  XLEN  instruction word; feeds the IF/ID data input.
REQ-014 fetch_stall_o  out  1  freezes the IF/ID register and the whole CPU while no instruction is available.

Function
REQ-015 The state machine SHALL have three states: IDLE, REQ and BUF.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to REQ; in IDLE: imem_req_o=0, fetch_stall_o=1, inst_o=0.
REQ-017 In REQ: imem_req_o=1, imem_addr_o=pc_q, fetch_stall_o=!imem_ack_i, inst_o=imem_ack_i ? imem_data_i : 0.
REQ-018 In BUF: imem_req_o=0, inst_o=buf_q, fetch_stall_o=0.
REQ-019 done = (REQ && imem_ack_i) || BUF.
REQ-020 advance = done && (branch_i || !stall_i); branch_i SHALL have priority over stall_i.
REQ-021 On advance, pc_q SHALL take branch_i ? {branch_target_i[XLEN-1:2],2'b00} : pc_q+4, and the state SHALL become REQ.
REQ-022 pc_q+4 SHALL wrap modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 REQ with imem_ack_i=1, stall_i=1 and branch_i=0 SHALL capture imem_data_i into buf_q and go to BUF; no new request is issued.
REQ-024 BUF SHALL remain while stall_i=1 and branch_i=0, holding pc_q and buf_q unchanged.
REQ-025 REQ with imem_ack_i=0 SHALL hold pc_q; branch_i or stall_i changes in this window SHALL NOT abort or change the outstanding request.
REQ-026 A redirect that arrives while in BUF SHALL discard buf_q.
REQ-027 Latency: with zero-wait memory and no stall, one instruction SHALL be presented per cycle, and the PC sequence SHALL be RESET_PC, +4, +8, ...
REQ-028 The redirect penalty SHALL be zero cycles beyond memory latency: the target fetch starts in the cycle after advance.

Reset
REQ-029 While rst_i=0: pc_q=RESET_PC, state=IDLE, buf_q=0, imem_req_o=0, inst_o=0, fetch_stall_o=1.
REQ-030 Reset asserted mid-request SHALL drop the request immediately, and any late imem_ack_i SHALL be ignored.

Structure
REQ-031 A shared package cpu_pkg SHALL hold the fetch state encoding, NOP_INST=0 and the default RESET_PC.
REQ-032 The block SHALL be a single module with no sub-module; the PC incrementer and the BUF register SHALL be inline.

Verification
REQ-033 Reset release, ack tied to 1 -> imem_addr_o sequence 0, 4, 8, 12; fetch_stall_o=1 for exactly the first (IDLE) cycle only.
REQ-034 Ack delayed 3 cycles at PC 0x10 -> fetch_stall_o=1 for 3 cycles, pc_o stays 0x10, then inst_o equals the returned word for one cycle, then PC becomes 0x14.
REQ-035 Hit at 0x20 with stall_i=1 for 2 cycles -> state BUF, no imem_req_o, inst_o held, pc_o=0x20; when stall drops, PC becomes 0x24.
REQ-036 branch_i=1, target 0x103, stall_i=1 at done -> next PC is 0x100, and the branch overrides the stall.
REQ-037 PC=0xFFFF_FFFC, zero-wait -> next PC is 0x0000_0000.
REQ-038 rst_i pulsed low during a pending request -> imem_req_o drops asynchronously, pc_o=RESET_PC, and a late ack has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, the NOP word and the default boot address.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_BUF  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues instruction-memory requests, buffers a word that arrives
// while ID is stalled, and freezes the pipeline until an instruction is available.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output logic            fetch_stall_o
);

    fetch_state_e    state_r;
    fetch_state_e    next_state_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] buf_r;
    logic            done_s;
    logic            advance_s;
    logic [XLEN-1:0] pc_next_s;

    // Instruction availability and the decision to move to the next PC; a redirect beats a stall.
    always_comb begin
        done_s    = ((state_r == ST_REQ) && imem_ack_i) || (state_r == ST_BUF);
        advance_s = done_s && (branch_i || !stall_i);
        if (branch_i) begin
            // Masking keeps the target word-aligned without leaving its low bits unread.
            pc_next_s = branch_target_i & ~XLEN'(32'h0000_0003);
        end else begin
            pc_next_s = pc_r + XLEN'(32'h0000_0004);
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: next_state_s = ST_REQ;
            ST_REQ: begin
                if (imem_ack_i && !advance_s) begin
                    next_state_s = ST_BUF;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_BUF: begin
                if (advance_s) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_BUF;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Program counter: only moves once the current instruction has been handed to ID.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_r <= RESET_PC;
        end else if (advance_s) begin
            pc_r <= pc_next_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Holding buffer for a word that arrived while ID was stalled; cleared when it is left.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_r <= XLEN'(NOP_INST);
        end else if ((state_r == ST_REQ) && imem_ack_i && !advance_s) begin
            buf_r <= imem_data_i;
        end else if ((state_r == ST_BUF) && advance_s) begin
            buf_r <= XLEN'(NOP_INST);
        end else begin
            buf_r <= buf_r;
        end
    end

    // Output decode; reset forces IDLE asynchronously, so the request drops at once.
    always_comb begin
        imem_req_o    = 1'b0;
        fetch_stall_o = 1'b1;
        inst_o        = XLEN'(NOP_INST);
        case (state_r)
            ST_IDLE: begin
                imem_req_o    = 1'b0;
                fetch_stall_o = 1'b1;
                inst_o        = XLEN'(NOP_INST);
            end
            ST_REQ: begin
                imem_req_o    = 1'b1;
                fetch_stall_o = !imem_ack_i;
                if (imem_ack_i) begin
                    inst_o = imem_data_i;
                end else begin
                    inst_o = XLEN'(NOP_INST);
                end
            end
            ST_BUF: begin
                imem_req_o    = 1'b0;
                fetch_stall_o = 1'b0;
                inst_o        = buf_r;
            end
            default: begin
                imem_req_o    = 1'b0;
                fetch_stall_o = 1'b1;
                inst_o        = XLEN'(NOP_INST);
            end
        endcase
    end

    assign imem_addr_o = pc_r;
    assign pc_o        = pc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected (pc, inst) pairs are queued by the stimulus and
// popped by a monitor whenever ID accepts an instruction; in-cycle checks cover stall behaviour.
module tb_instr_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        fetch_stall_o;
    logic        ack_r;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .fetch_stall_o   (fetch_stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: word is C0DE in the upper half and the low address bits below; junk without ack.
    assign imem_ack_i  = ack_r;
    assign imem_data_i = ack_r ? {16'hC0DE, imem_addr_o[15:0]} : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back('{pc: pc, inst: inst});
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: an instruction is consumed when it is available and ID either redirects or is not stalled.
    always @(negedge clk_i) begin
        if (rst_i && !fetch_stall_o && (branch_i || !stall_i)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %h inst %h expected nothing", pc_o, inst_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", pc_o, e.pc);
                chk("sb_inst", inst_o, e.inst);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b0; ack_r = 1'b1; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_pc", pc_o, 32'h0000_0000);
        chk("rst_req", {31'h0, imem_req_o}, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_fstall", {31'h0, fetch_stall_o}, 32'h1);

        cyc();
        rst_i = 1'b1;
        #1;
        chk("idle_fstall", {31'h0, fetch_stall_o}, 32'h1);
        chk("idle_req", {31'h0, imem_req_o}, 32'h0);
        chk("idle_inst", inst_o, 32'h0);
        push(32'h0000_0000, 32'hC0DE_0000);
        push(32'h0000_0004, 32'hC0DE_0004);
        push(32'h0000_0008, 32'hC0DE_0008);
        push(32'h0000_000C, 32'hC0DE_000C);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("seq_addr", imem_addr_o, 32'(i * 4));
            chk("seq_fstall", {31'h0, fetch_stall_o}, 32'h0);
        end

        // Three wait cycles at 0x10; ID signals wiggle but must not disturb the request.
        for (int i = 0; i < 3; i++) begin
            cyc();
            ack_r = 1'b0;
            branch_i = (i == 1); stall_i = (i == 1); branch_target_i = 32'h0000_0400;
            #1;
            chk("wait_pc", pc_o, 32'h0000_0010);
            chk("wait_fstall", {31'h0, fetch_stall_o}, 32'h1);
            chk("wait_inst", inst_o, 32'h0);
            chk("wait_req", {31'h0, imem_req_o}, 32'h1);
        end
        cyc();
        ack_r = 1'b1; branch_i = 1'b0; stall_i = 1'b0;
        push(32'h0000_0010, 32'hC0DE_0010);
        #1;
        chk("ack_inst", inst_o, 32'hC0DE_0010);
        cyc(); push(32'h0000_0014, 32'hC0DE_0014); #1;
        chk("after_wait_pc", pc_o, 32'h0000_0014);
        cyc(); push(32'h0000_0018, 32'hC0DE_0018);
        cyc(); push(32'h0000_001C, 32'hC0DE_001C);

        // Hit at 0x20 under stall: word goes to the buffer and is held for two cycles.
        cyc();
        stall_i = 1'b1;
        push(32'h0000_0020, 32'hC0DE_0020);
        #1;
        chk("hit_fstall", {31'h0, fetch_stall_o}, 32'h0);
        cyc();
        ack_r = 1'b0;
        #1;
        chk("buf_req", {31'h0, imem_req_o}, 32'h0);
        chk("buf_inst", inst_o, 32'hC0DE_0020);
        chk("buf_pc", pc_o, 32'h0000_0020);
        chk("buf_fstall", {31'h0, fetch_stall_o}, 32'h0);
        cyc();
        stall_i = 1'b0;
        #1;
        chk("buf_inst_hold", inst_o, 32'hC0DE_0020);
        chk("buf_req_hold", {31'h0, imem_req_o}, 32'h0);

        // Branch to 0x103 while stalled: redirect wins, target is word-aligned.
        cyc();
        ack_r = 1'b1; stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h0000_0103;
        push(32'h0000_0024, 32'hC0DE_0024);
        #1;
        chk("pre_br_pc", pc_o, 32'h0000_0024);
        cyc();
        branch_i = 1'b0; stall_i = 1'b1;
        push(32'h0000_0100, 32'hC0DE_0100);
        #1;
        chk("br_target_pc", pc_o, 32'h0000_0100);

        // Redirect out of BUF to the top of the address space; buffered word is dropped.
        cyc();
        branch_i = 1'b1; stall_i = 1'b1; ack_r = 1'b0; branch_target_i = 32'hFFFF_FFFC;
        #1;
        chk("buf2_req", {31'h0, imem_req_o}, 32'h0);
        chk("buf2_inst", inst_o, 32'hC0DE_0100);
        cyc();
        branch_i = 1'b0; stall_i = 1'b0; ack_r = 1'b1;
        push(32'hFFFF_FFFC, 32'hC0DE_FFFC);
        #1;
        chk("top_pc", pc_o, 32'hFFFF_FFFC);
        cyc();
        push(32'h0000_0000, 32'hC0DE_0000);
        #1;
        chk("wrap_pc", pc_o, 32'h0000_0000);

        // Reset pulse during a pending request at 0x4, then a late ack in IDLE.
        cyc();
        ack_r = 1'b0;
        #1;
        chk("pend_pc", pc_o, 32'h0000_0004);
        chk("pend_req", {31'h0, imem_req_o}, 32'h1);
        #1;
        rst_i = 1'b0;
        #1;
        chk("arst_req", {31'h0, imem_req_o}, 32'h0);
        chk("arst_pc", pc_o, 32'h0000_0000);
        chk("arst_fstall", {31'h0, fetch_stall_o}, 32'h1);
        cyc();
        ack_r = 1'b1; rst_i = 1'b1;
        #1;
        chk("late_ack_req", {31'h0, imem_req_o}, 32'h0);
        chk("late_ack_fstall", {31'h0, fetch_stall_o}, 32'h1);
        chk("late_ack_inst", inst_o, 32'h0);
        chk("late_ack_pc", pc_o, 32'h0000_0000);
        cyc();
        push(32'h0000_0000, 32'hC0DE_0000);
        #1;
        chk("restart_pc", pc_o, 32'h0000_0000);
        cyc();
        ack_r = 1'b0;
        #1;
        chk("restart_next_pc", pc_o, 32'h0000_0004);
        chk("restart_fstall", {31'h0, fetch_stall_o}, 32'h1);
        repeat (2) cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
